// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: counter encodings, index modes,
// FSM states and the table index hash.
package bp_pkg;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  localparam int MODE_BIMODAL = 0;
  localparam int MODE_GSHARE  = 1;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bp_state_e;

  // Word-address hash; caller keeps the low BHT_ADDR_BITS and passes zero history for bimodal.
  function automatic logic [31:0] bp_index(input logic [31:0] pc, input logic [31:0] ghr);
    return (pc >> 2) ^ ghr;
  endfunction

endpackage

// File: rtl/bp_ras.sv
// Circular return-address stack: push/pop with saturating depth count, oldest
// entry overwritten on overflow; simultaneous push+pop replaces the top entry.
module bp_ras #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] push_data,
  output logic [31:0] top,
  output logic        empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] ptr;
  logic [PW-1:0] top_ptr;
  logic [PW:0]   count;

  assign top_ptr = ptr - 1'b1;
  assign top     = mem[top_ptr];
  assign empty   = (count == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr   <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && pop) begin
      mem[top_ptr] <= push_data;
    end else if (push) begin
      mem[ptr] <= push_data;
      ptr      <= ptr + 1'b1;
      if (count != CNT_FULL) count <= count + 1'b1;
    end else if (pop && !empty) begin
      ptr   <= top_ptr;
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// 2-bit counter branch predictor (bimodal or gshare) with speculative GHR and
// mispredict repair. Optional return-address stack enabled by BP_RAS_EN.
//
// state | meaning
// INIT  | sweeping counter table to WNT, one entry per cycle; lookups/updates ignored
// RUN   | normal predict/update operation, ready=1
module branch_predictor import bp_pkg::*; #(
  parameter int BHT_ADDR_BITS = 4,
  parameter int GHR_BITS      = 4,
  parameter int MODE          = 0,
  parameter int RAS_DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  output logic                     ready,
  input  logic                     p_valid,
  input  logic [31:0]              p_PC,
  input  logic                     p_isB,
  input  logic                     p_isCall,
  input  logic                     p_isRet,
  input  logic [31:0]              p_link,
  output logic                     p_taken,
  output logic [BHT_ADDR_BITS-1:0] p_index,
  output logic [GHR_BITS-1:0]      p_ghr,
  output logic                     ras_hit,
  output logic [31:0]              ras_target,
  input  logic                     u_valid,
  input  logic [BHT_ADDR_BITS-1:0] u_index,
  input  logic [GHR_BITS-1:0]      u_ghr,
  input  logic                     u_taken,
  input  logic                     u_mispredict
);

  localparam int B       = BHT_ADDR_BITS;
  localparam int G       = GHR_BITS;
  localparam int ENTRIES = 1 << B;

  bp_state_e   state;
  logic [B-1:0] sweep_ptr;
  logic [G-1:0] ghr;
  logic [G-1:0] ghr_spec;
  logic [G-1:0] ghr_fix;
  logic [1:0]   cnt [ENTRIES];
  logic [1:0]   cnt_cur;
  logic [1:0]   cnt_next;
  logic [31:0]  ghr_ext;
  logic [31:0]  idx_full;
  logic         run;
  logic         unused_idx;

  assign run      = (state == RUN);
  assign ghr_ext  = (MODE == MODE_GSHARE) ? {{(32-G){1'b0}}, ghr} : '0;
  assign idx_full = bp_index(p_PC, ghr_ext);
  assign p_index  = idx_full[B-1:0];
  assign unused_idx = ^idx_full[31:B];
  assign p_taken  = run & p_isB & cnt[p_index][1];
  assign p_ghr    = ghr;

  generate
    if (G == 1) begin : g_ghr1
      logic unused_u_ghr;
      assign ghr_spec     = p_taken;
      assign ghr_fix      = u_taken;
      assign unused_u_ghr = ^u_ghr;
    end else begin : g_ghrn
      logic unused_u_ghr_msb;
      assign ghr_spec         = {ghr[G-2:0], p_taken};
      assign ghr_fix          = {u_ghr[G-2:0], u_taken};
      assign unused_u_ghr_msb = u_ghr[G-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= INIT;
      sweep_ptr <= '0;
      ready     <= 1'b0;
      ghr       <= '0;
    end else begin
      case (state)
        INIT: begin
          sweep_ptr <= sweep_ptr + 1'b1;
          if (sweep_ptr == {B{1'b1}}) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          // Repair wins: a same-cycle lookup is already on the wrong path.
          if (u_valid && u_mispredict) ghr <= ghr_fix;
          else if (p_valid && p_isB)   ghr <= ghr_spec;
        end
        default: state <= INIT;
      endcase
    end
  end

  always_comb begin
    cnt_cur  = cnt[u_index];
    cnt_next = cnt_cur;
    if (u_taken) begin
      if (cnt_cur != CNT_ST) cnt_next = cnt_cur + 1'b1;
    end else begin
      if (cnt_cur != CNT_SNT) cnt_next = cnt_cur - 1'b1;
    end
  end

  // Table is cleared by the sweep rather than by reset fan-out.
  always_ff @(posedge clk) begin
    if (state == INIT)  cnt[sweep_ptr] <= CNT_WNT;
    else if (u_valid)   cnt[u_index]   <= cnt_next;
  end

`ifdef BP_RAS_EN
  logic        ras_empty;
  logic [31:0] ras_top;

  bp_ras #(.DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .resetn    (resetn),
    .push      (run & p_valid & p_isCall),
    .pop       (run & p_valid & p_isRet),
    .push_data (p_link),
    .top       (ras_top),
    .empty     (ras_empty)
  );

  assign ras_hit    = run & p_isRet & ~ras_empty;
  assign ras_target = ras_empty ? '0 : ras_top;
`else
  logic unused_ras;
  assign unused_ras = ^{p_isCall, p_isRet, p_link};
  assign ras_hit    = 1'b0;
  assign ras_target = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: one bimodal and one gshare instance on shared stimulus.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        resetn;
  logic        p_valid, p_isB, p_isCall, p_isRet;
  logic [31:0] p_PC, p_link;
  logic        u_valid, u_taken, u_mispredict;
  logic [3:0]  u_index, u_ghr;

  logic        rdy_bi, tk_bi, hit_bi;
  logic [3:0]  idx_bi, ghr_bi;
  logic [31:0] tgt_bi;
  logic        rdy_gs, tk_gs, hit_gs;
  logic [3:0]  idx_gs, ghr_gs;
  logic [31:0] tgt_gs;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  branch_predictor #(.BHT_ADDR_BITS(4), .GHR_BITS(4), .MODE(0), .RAS_DEPTH(4)) dut_bi (
    .clk(clk), .resetn(resetn), .ready(rdy_bi),
    .p_valid(p_valid), .p_PC(p_PC), .p_isB(p_isB), .p_isCall(p_isCall), .p_isRet(p_isRet),
    .p_link(p_link), .p_taken(tk_bi), .p_index(idx_bi), .p_ghr(ghr_bi),
    .ras_hit(hit_bi), .ras_target(tgt_bi),
    .u_valid(u_valid), .u_index(u_index), .u_ghr(u_ghr), .u_taken(u_taken),
    .u_mispredict(u_mispredict)
  );

  branch_predictor #(.BHT_ADDR_BITS(4), .GHR_BITS(4), .MODE(1), .RAS_DEPTH(4)) dut_gs (
    .clk(clk), .resetn(resetn), .ready(rdy_gs),
    .p_valid(p_valid), .p_PC(p_PC), .p_isB(p_isB), .p_isCall(p_isCall), .p_isRet(p_isRet),
    .p_link(p_link), .p_taken(tk_gs), .p_index(idx_gs), .p_ghr(ghr_gs),
    .ras_hit(hit_gs), .ras_target(tgt_gs),
    .u_valid(u_valid), .u_index(u_index), .u_ghr(u_ghr), .u_taken(u_taken),
    .u_mispredict(u_mispredict)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    p_valid = 0; p_isB = 0; p_isCall = 0; p_isRet = 0;
    p_PC = '0; p_link = '0;
    u_valid = 0; u_taken = 0; u_mispredict = 0; u_index = '0; u_ghr = '0;
  endtask

  task automatic upd(input logic [3:0] idx, input logic taken, input logic misp,
                     input logic [3:0] ghr);
    u_valid = 1; u_index = idx; u_taken = taken; u_mispredict = misp; u_ghr = ghr;
    tick();
    u_valid = 0; u_mispredict = 0;
  endtask

  task automatic look(input logic [31:0] pc);
    p_PC = pc; p_isB = 1; p_valid = 0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    idle();
    resetn = 0;
    repeat (2) @(posedge clk);
    #1;
    look(32'h40);
    chk("rst_ready_bi", rdy_bi, 0);
    chk("rst_ready_gs", rdy_gs, 0);
    chk("rst_taken", tk_gs, 0);
    chk("rst_ghr", ghr_gs, 0);
    chk("rst_ras_hit", hit_gs, 0);
    chk("rst_ras_target", tgt_gs, 0);

    // Release reset with live lookups/updates that INIT must ignore.
    resetn = 1;
    p_valid = 1; p_isB = 1; p_PC = 32'h40;
    u_valid = 1; u_mispredict = 1; u_taken = 1; u_ghr = 4'hF; u_index = 4'd0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("sweep_ready_bi", rdy_bi, (i == 16));
      chk("sweep_ready_gs", rdy_gs, (i == 16));
      if (i == 8) chk("init_taken_forced", tk_gs, 0);
    end
    idle();
    #1;
    chk("init_ghr_bi", ghr_bi, 0);
    chk("init_ghr_gs", ghr_gs, 0);

    for (int i = 0; i < 16; i++) begin
      look(32'(i) << 2);
      chk("wnt_taken_bi", tk_bi, 0);
      chk("wnt_taken_gs", tk_gs, 0);
      chk("idx_gs_ghr0", idx_gs, i);
    end
    p_isB = 0;

    // Saturation high at idx 0 (PC 0x40).
    upd(4'd0, 1, 0, 4'd0); look(32'h40); chk("inc1_taken", tk_bi, 1);
    chk("idx_bi_40", idx_bi, 0);
    upd(4'd0, 1, 0, 4'd0);
    upd(4'd0, 1, 0, 4'd0); look(32'h40); chk("sat_hi_taken", tk_bi, 1);
    upd(4'd0, 0, 0, 4'd0); look(32'h40); chk("dec_from_st", tk_bi, 1);
    upd(4'd0, 0, 0, 4'd0); look(32'h40); chk("dec_to_wnt", tk_gs, 0);

    // Saturation low at idx 1 (PC 0x44).
    upd(4'd1, 0, 0, 4'd0);
    upd(4'd1, 0, 0, 4'd0); look(32'h44); chk("sat_lo_taken", tk_bi, 0);
    upd(4'd1, 1, 0, 4'd0); look(32'h44); chk("inc_from_snt", tk_bi, 0);
    upd(4'd1, 1, 0, 4'd0); look(32'h44); chk("inc_to_wt", tk_bi, 1);

    // Same-cycle lookup and update of idx 3: no bypass.
    p_PC = 32'h4C; p_isB = 1;
    u_valid = 1; u_index = 4'd3; u_taken = 1;
    #1;
    chk("same_cycle_taken", tk_gs, 0);
    tick();
    u_valid = 0;
    #1;
    chk("after_update_taken", tk_gs, 1);

    // Gshare: repair to GHR 0101 (also trains idx 5 to WT).
    upd(4'd5, 1, 1, 4'b0010);
    chk("repair_ghr_bi", ghr_bi, 4'b0101);
    chk("repair_ghr_gs", ghr_gs, 4'b0101);
    look(32'h40);
    chk("gs_index", idx_gs, 4'b0101);
    chk("bi_index", idx_bi, 4'b0000);
    chk("gs_taken", tk_gs, 1);
    chk("bi_taken", tk_bi, 0);
    p_valid = 1;
    tick();
    p_valid = 0;
    chk("spec_ghr_gs", ghr_gs, 4'b1011);
    chk("spec_ghr_bi", ghr_bi, 4'b1010);

    p_valid = 1; p_isB = 1; p_PC = 32'h40;
    upd(4'd9, 0, 1, 4'b0101);
    p_valid = 0;
    chk("repair_wins_gs", ghr_gs, 4'b1010);
    chk("repair_wins_bi", ghr_bi, 4'b1010);
    look(32'h40);
    chk("gs_index_1010", idx_gs, 4'b1010);
    p_isB = 0; p_valid = 1;
    tick();
    p_valid = 0;
    chk("nonbranch_no_shift", ghr_gs, 4'b1010);

    // RAS: one call then one return.
    p_valid = 1; p_isCall = 1; p_link = 32'h104;
    tick();
    p_isCall = 0; p_isRet = 1;
    #1;
`ifdef BP_RAS_EN
    chk("ras_single_hit", hit_gs, 1);
    chk("ras_single_target", tgt_gs, 32'h104);
`else
    chk("ras_off_hit", hit_gs, 0);
    chk("ras_off_target", tgt_gs, 0);
`endif
    tick();
    p_isRet = 0; p_valid = 0;

`ifdef BP_RAS_EN
    p_valid = 1; p_isCall = 1;
    for (int k = 0; k < 5; k++) begin
      p_link = 32'h104 + 32'(4 * k);
      tick();
    end
    p_isCall = 0; p_isRet = 1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("ras_pop_hit", hit_gs, (k < 4));
      if (k < 4) chk("ras_pop_target", tgt_gs, 32'h114 - 32'(4 * k));
      tick();
    end
    p_isRet = 0; p_isCall = 1; p_link = 32'h200;
    tick();
    p_isRet = 1; p_link = 32'h300;
    #1;
    chk("ras_callret_top_before", tgt_gs, 32'h200);
    tick();
    p_isCall = 0;
    #1;
    chk("ras_callret_hit", hit_gs, 1);
    chk("ras_callret_target", tgt_gs, 32'h300);
    tick();
    chk("ras_callret_empty", hit_gs, 0);
    p_isRet = 0; p_valid = 0;
`endif

    // Mid-run reset, then reset mid-sweep at ptr 7.
    look(32'h54);
    chk("pre_reset_taken", tk_bi, 1);
    #2 resetn = 0;
    #1;
    chk("midrun_ready", rdy_gs, 0);
    chk("midrun_ghr", ghr_gs, 0);
    chk("midrun_taken", tk_bi, 0);
    @(posedge clk);
    #1 resetn = 1;
    repeat (7) tick();
    chk("pre_midsweep_ready", rdy_gs, 0);
    #2 resetn = 0;
    #1;
    chk("midsweep_ready", rdy_gs, 0);
    @(posedge clk);
    #1 resetn = 1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("resweep_ready", rdy_gs, (i == 16));
    end
    look(32'h54);
    chk("resweep_idx5_bi", tk_bi, 0);
    chk("resweep_idx5_gs", tk_gs, 0);
    look(32'h4C);
    chk("resweep_idx3", tk_bi, 0);
    chk("resweep_ghr", ghr_bi, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
